// File: rtl/nested_int_ctrl.sv
// Nested vectored interrupt controller: priority take, IM save/restore stack, fetch redirect.
// Latency: level irq_i to pc_jump in 3 edges; takes stall while a redirect is in flight, during ERET, or when the stack is full.
module nested_int_ctrl #(
    parameter int                 NUM_IRQ     = 8,
    parameter int                 STACK_DEPTH = 8,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK   = '0,
    parameter logic [31:0]        VEC_BASE    = 32'h0000_0800,
    parameter logic [31:0]        VEC_STRIDE  = 32'h4,
    localparam int                DW          = $clog2(STACK_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [31:0]        current_pc,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic               eret,
    input  logic               status_we,
    input  logic [31:0]        status_wdata,
    output logic [31:0]        status,
    output logic [31:0]        epc,
    output logic               pc_jump,
    output logic [31:0]        pc_addr,
    output logic               writeback_mask,
    output logic [3:0]         cur_irq,
    output logic [DW-1:0]      depth,
    output logic               stack_full,
    output logic               underflow
);

    localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [NUM_IRQ-1:0] sync1_q, irq_s_q, irq_prev_q;
    logic [NUM_IRQ-1:0] edge_pend_q, edge_pend_d;
    logic [NUM_IRQ-1:0] pending, active, rise, take_onehot;

    logic               ie_q, ie_d;
    logic [NUM_IRQ-1:0] im_q, im_d;
    logic               pc_jump_q, pc_jump_d;
    logic [31:0]        pc_addr_q, pc_addr_d;
    logic               wbm_q, wbm_d;
    logic [DW-1:0]      depth_q, depth_d;
    logic               underflow_q, underflow_d;

    logic [31:0]        stk_pc_q  [STACK_DEPTH];
    logic [NUM_IRQ-1:0] stk_im_q  [STACK_DEPTH];
    logic [3:0]         stk_irq_q [STACK_DEPTH];

    logic               take, do_pop, empty;
    logic [3:0]         sel_n;
    logic [31:0]        vec_addr, mask32;
    logic [AW-1:0]      push_a, top_a;
    logic               unused_bits;

    assign pending = (EDGE_MASK & edge_pend_q) | (~EDGE_MASK & irq_s_q);
    assign active  = pending & im_q;
    assign rise    = irq_s_q & ~irq_prev_q;

    always_comb begin
        sel_n = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (active[i]) sel_n = 4'(i);
        end
    end

    assign empty      = (depth_q == '0);
    assign stack_full = (depth_q == DW'(STACK_DEPTH));
    assign push_a     = AW'(depth_q);
    assign top_a      = AW'(depth_q - DW'(1));

    // ERET has priority over a take on the same edge, so the take term excludes it.
    assign take   = ie_q & (|active) & ~pc_jump_q & ~stack_full & ~eret;
    assign do_pop = eret & ~empty;

    assign vec_addr    = VEC_BASE + 32'(sel_n) * VEC_STRIDE;
    assign mask32      = (32'd2 << sel_n) - 32'd1;
    assign take_onehot = take ? (NUM_IRQ'(1) << sel_n) : '0;

    // A fresh rising edge on the take cycle re-arms the channel.
    assign edge_pend_d = EDGE_MASK & ((edge_pend_q & ~take_onehot) | rise);
    assign underflow_d = underflow_q | (eret & empty);

    always_comb begin
        ie_d      = ie_q;
        im_d      = im_q;
        pc_jump_d = 1'b0;
        wbm_d     = 1'b1;
        pc_addr_d = pc_addr_q;
        depth_d   = depth_q;
        if (do_pop) begin
            pc_addr_d = stk_pc_q[top_a];
            im_d      = stk_im_q[top_a];
            pc_jump_d = 1'b1;
            depth_d   = depth_q - DW'(1);
        end else if (take) begin
            pc_addr_d = vec_addr;
            im_d      = im_q & ~mask32[NUM_IRQ-1:0];
            pc_jump_d = 1'b1;
            wbm_d     = 1'b0;
            depth_d   = depth_q + DW'(1);
        end else if (status_we && !eret) begin
            ie_d = status_wdata[0];
            im_d = status_wdata[8 +: NUM_IRQ];
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync1_q     <= '0;
            irq_s_q     <= '0;
            irq_prev_q  <= '0;
            edge_pend_q <= '0;
            ie_q        <= 1'b1;
            im_q        <= '1;
            pc_jump_q   <= 1'b0;
            pc_addr_q   <= '0;
            wbm_q       <= 1'b1;
            depth_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            sync1_q     <= irq_i;
            irq_s_q     <= sync1_q;
            irq_prev_q  <= irq_s_q;
            edge_pend_q <= edge_pend_d;
            ie_q        <= ie_d;
            im_q        <= im_d;
            pc_jump_q   <= pc_jump_d;
            pc_addr_q   <= pc_addr_d;
            wbm_q       <= wbm_d;
            depth_q     <= depth_d;
            underflow_q <= underflow_d;
        end
    end

    // Frame contents need no reset: depth alone says which entries are live.
    always_ff @(posedge clk) begin
        if (take) begin
            stk_pc_q[push_a]  <= current_pc;
            stk_im_q[push_a]  <= im_q;
            stk_irq_q[push_a] <= sel_n;
        end
    end

    always_comb begin
        status               = '0;
        status[0]            = ie_q;
        status[8 +: NUM_IRQ] = im_q;
    end

    assign epc            = empty ? 32'd0 : stk_pc_q[top_a];
    assign cur_irq        = empty ? 4'd0 : stk_irq_q[top_a];
    assign pc_jump        = pc_jump_q;
    assign pc_addr        = pc_addr_q;
    assign writeback_mask = wbm_q;
    assign depth          = depth_q;
    assign underflow      = underflow_q;

    assign unused_bits = ^{status_wdata[31:8+NUM_IRQ], status_wdata[7:1], mask32[31:NUM_IRQ]};

endmodule
